// File: rtl/cla_pipelined_adder.sv
// Pipelined add/subtract unit. Each stage resolves one SLICE-bit slice through
// cascaded 4-bit carry-lookahead groups; the slice carry is registered into the next stage.
module cla_pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryInput,
  input  logic             subtract,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] sum,
  output logic             carryOutput,
  output logic             overflow
);

  localparam int STAGES = WIDTH / SLICE;
  localparam int GROUPS = SLICE / 4;

  // Returns {carry into bit 3, carry out, 4-bit sum} of one lookahead group.
  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic cin);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;
    p    = x ^ y;
    g    = x & y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c[3], c[4], p ^ c[3:0]};
  endfunction

  // Level 0 is the input register; level k+1 is the output of stage k.
  logic             vld_p [0:STAGES];
  logic [WIDTH-1:0] acc_p [0:STAGES];
  logic             cry_p [0:STAGES];
  logic [WIDTH-1:0] opA_p [0:STAGES-1];
  logic [WIDTH-1:0] opB_p [0:STAGES-1];
  logic             ovf_p;

  logic [WIDTH-1:0] accNxt [0:STAGES-1];
  logic             cryNxt [0:STAGES-1];
  logic             msbCin;
  logic [5:0]       grp;
  logic             advance;

  assign advance     = ~vld_p[STAGES] | outReady;
  assign inReady     = advance & ~rst;
  assign outValid    = vld_p[STAGES];
  assign sum         = acc_p[STAGES];
  assign carryOutput = cry_p[STAGES];
  assign overflow    = ovf_p;

  // msbCin ends holding the carry into the top column of the last stage.
  always_comb begin
    grp    = '0;
    msbCin = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      accNxt[k] = acc_p[k];
      cryNxt[k] = cry_p[k];
      for (int g = 0; g < GROUPS; g++) begin
        grp = cla4(opA_p[k][k*SLICE+4*g +: 4], opB_p[k][k*SLICE+4*g +: 4], cryNxt[k]);
        accNxt[k][k*SLICE+4*g +: 4] = grp[3:0];
        cryNxt[k] = grp[4];
        msbCin    = grp[5];
      end
    end
  end

  // Valid chain: every level shifts on advance, bubbles included.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= STAGES; k++) vld_p[k] <= 1'b0;
    end else if (advance) begin
      vld_p[0] <= inValid;
      for (int k = 0; k < STAGES; k++) vld_p[k+1] <= vld_p[k];
    end
  end

  // Datapath: operands are conditioned for subtraction as they enter level 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p[STAGES] <= '0;
      cry_p[STAGES] <= 1'b0;
      ovf_p         <= 1'b0;
    end else if (advance) begin
      opA_p[0] <= a;
      opB_p[0] <= b ^ {WIDTH{subtract}};
      cry_p[0] <= carryInput ^ subtract;
      acc_p[0] <= '0;
      for (int k = 0; k < STAGES; k++) begin
        acc_p[k+1] <= accNxt[k];
        cry_p[k+1] <= cryNxt[k];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        opA_p[k+1] <= opA_p[k];
        opB_p[k+1] <= opB_p[k];
      end
      ovf_p <= msbCin ^ cryNxt[STAGES-1];
    end
  end

endmodule
